// File: rtl/bpb_sa_pkg.sv
// Shared types and helpers for the set-associative branch prediction buffer.
package bpb_sa_pkg;

  typedef logic [31:0] word_t;

  // Prediction / resolution payload: direction plus target.
  typedef struct packed {
    logic  taken;
    word_t destpc;
  } bpb_result_t;

  // 2-bit counter with hysteresis; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Tag width for a given number of index bits (word-aligned PCs).
  function automatic int bpb_tag_width(input int ew);
    return 30 - ew;
  endfunction

  // Counter next state. Taken always heads towards ST through WNT.
  // Not-taken drops ST to WT and everything else straight to SNT.
  function automatic ctr_e ctr_next(input ctr_e s, input logic taken);
    ctr_e n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? ST  : SNT;
      ST:      n = taken ? ST  : WT;
      WT:      n = taken ? ST  : SNT;
      default: n = SNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bpb_sa_set.sv
// One set of the prediction buffer: WAYS entries, a round-robin victim
// pointer, PORTS combinational tag-compare read ports and one write port.
module bpb_set
  import bpb_sa_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int PORTS = 2,
  parameter int TAG_W = 26
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_i,
  input  logic                            wr_en_i,
  input  logic [TAG_W-1:0]                wr_tag_i,
  input  bpb_result_t                     wr_result_i,
  input  logic [PORTS-1:0][TAG_W-1:0]     rd_tag_i,
  output logic [PORTS-1:0]                rd_hit_o,
  output bpb_result_t [PORTS-1:0]         rd_result_o
);

  // A single-way set still needs a one-bit pointer to keep widths legal.
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_q, valid_d;
  logic [VW-1:0]    victim_q, victim_d;
  logic [TAG_W-1:0] tag_q  [WAYS];
  logic [TAG_W-1:0] tag_d  [WAYS];
  word_t            dest_q [WAYS];
  word_t            dest_d [WAYS];
  ctr_e             ctr_q  [WAYS];
  ctr_e             ctr_d  [WAYS];

  logic          wrHit;
  logic [VW-1:0] wrHitWay;
  logic          freeFound;
  logic [VW-1:0] freeWay;
  logic [VW-1:0] allocWay;

  // Read ports: lowest-numbered valid way with a matching tag wins.
  always_comb begin
    logic found;
    for (int p = 0; p < PORTS; p++) begin
      found          = 1'b0;
      rd_hit_o[p]    = 1'b0;
      rd_result_o[p] = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (!found && valid_q[w] && (tag_q[w] == rd_tag_i[p])) begin
          found                 = 1'b1;
          rd_hit_o[p]           = 1'b1;
          rd_result_o[p].taken  = ctr_q[w][1];
          rd_result_o[p].destpc = dest_q[w];
        end
      end
    end
  end

  // Write-side lookup: find the hitting way and the first free way.
  always_comb begin
    wrHit     = 1'b0;
    wrHitWay  = '0;
    freeFound = 1'b0;
    freeWay   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!wrHit && valid_q[w] && (tag_q[w] == wr_tag_i)) begin
        wrHit    = 1'b1;
        wrHitWay = VW'(w);
      end
      if (!freeFound && !valid_q[w]) begin
        freeFound = 1'b1;
        freeWay   = VW'(w);
      end
    end
  end

  assign allocWay = freeFound ? freeWay : victim_q;

  // Next-state: flush beats any write; hits train, taken misses allocate.
  always_comb begin
    valid_d  = valid_q;
    victim_d = victim_q;
    tag_d    = tag_q;
    dest_d   = dest_q;
    ctr_d    = ctr_q;
    if (flush_i) begin
      valid_d  = '0;
      victim_d = '0;
    end else if (wr_en_i) begin
      if (wrHit) begin
        ctr_d[wrHitWay] = ctr_next(ctr_q[wrHitWay], wr_result_i.taken);
        if (wr_result_i.taken) begin
          dest_d[wrHitWay] = wr_result_i.destpc;
        end
      end else if (wr_result_i.taken) begin
        valid_d[allocWay] = 1'b1;
        tag_d[allocWay]   = wr_tag_i;
        dest_d[allocWay]  = wr_result_i.destpc;
        ctr_d[allocWay]   = WNT;
        if (!freeFound) begin
          victim_d = (WAYS == 1) ? '0 : victim_q + VW'(1);
        end
      end
    end
  end

  // Control state: valid bits and victim pointer are the only reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else begin
      valid_q  <= valid_d;
      victim_q <= victim_d;
    end
  end

  // Entry payload: meaningless until its valid bit is set, so never reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    dest_q <= dest_d;
    ctr_q  <= ctr_d;
  end

endmodule

// File: rtl/bpb_sa.sv
// Set-associative branch prediction buffer: 2^ENTRY_WIDTH sets of WAYS ways
// (WAYS must be 1, 2 or 4), PORTS combinational lookups, one commit update.
module bpb_sa
  import bpb_sa_pkg::*;
#(
  parameter int ENTRY_WIDTH = 4,
  parameter int WAYS        = 2,
  parameter int PORTS       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  word_t             pc_predict     [PORTS],
  output logic [PORTS-1:0]  hit_predict,
  output bpb_result_t       destpc_predict [PORTS],
  input  word_t             pc_commit,
  input  logic              wen,
  input  bpb_result_t       destpc_commit
);

  localparam int SETS  = 1 << ENTRY_WIDTH;
  localparam int TAG_W = bpb_tag_width(ENTRY_WIDTH);

  logic [PORTS-1:0][TAG_W-1:0] rdTag;
  logic [PORTS-1:0]            setHit [SETS];
  bpb_result_t [PORTS-1:0]     setRes [SETS];
  logic [SETS-1:0]             setWen;

  logic [ENTRY_WIDTH-1:0] commitIdx;
  logic [TAG_W-1:0]       commitTag;
  logic                   updEn;
  logic                   unusedPcBits;

  assign commitIdx = pc_commit[ENTRY_WIDTH+1:2];
  assign commitTag = pc_commit[31:ENTRY_WIDTH+2];
  assign updEn     = wen & ~stall & ~flush;

  // Lookup tags are broadcast to every set; the index picks the result.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rdTag[p] = pc_predict[p][31:ENTRY_WIDTH+2];
    end
  end

  // Byte-offset bits carry no information for word-aligned branches.
  always_comb begin
    unusedPcBits = ^pc_commit[1:0];
    for (int p = 0; p < PORTS; p++) begin
      unusedPcBits = unusedPcBits ^ (^pc_predict[p][1:0]);
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : gSet
    assign setWen[s] = updEn && (commitIdx == ENTRY_WIDTH'(s));

    bpb_set #(
      .WAYS  (WAYS),
      .PORTS (PORTS),
      .TAG_W (TAG_W)
    ) uSet (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .wr_en_i     (setWen[s]),
      .wr_tag_i    (commitTag),
      .wr_result_i (destpc_commit),
      .rd_tag_i    (rdTag),
      .rd_hit_o    (setHit[s]),
      .rd_result_o (setRes[s])
    );
  end

  // Select each port's answer from the set addressed by its own PC.
  always_comb begin
    logic [ENTRY_WIDTH-1:0] idx;
    for (int p = 0; p < PORTS; p++) begin
      idx               = pc_predict[p][ENTRY_WIDTH+1:2];
      hit_predict[p]    = setHit[idx][p];
      destpc_predict[p] = setRes[idx][p];
    end
  end

endmodule

// File: tb/tb_bpb_sa.sv
// Directed bench for bpb_sa with default parameters (16 sets, 2 ways, 2 ports).
module tb_bpb_sa;
  import bpb_sa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  word_t       pcPredict [2];
  logic [1:0]  hitPredict;
  bpb_result_t destpcPredict [2];
  word_t       pcCommit;
  logic        wen;
  bpb_result_t destpcCommit;

  int assertCount = 0;
  int failCount   = 0;

  bpb_sa #(.ENTRY_WIDTH(4), .WAYS(2), .PORTS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .pc_predict     (pcPredict),
    .hit_predict    (hitPredict),
    .destpc_predict (destpcPredict),
    .pc_commit      (pcCommit),
    .wen            (wen),
    .destpc_commit  (destpcCommit)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the commit-side inputs.
  task automatic applyStimulus(input logic w, input word_t pc, input logic tk, input word_t dest);
    wen                 = w;
    pcCommit            = pc;
    destpcCommit.taken  = tk;
    destpcCommit.destpc = dest;
  endtask

  // Drive both lookup ports and let the combinational path settle.
  task automatic lookup(input word_t pc0, input word_t pc1);
    pcPredict[0] = pc0;
    pcPredict[1] = pc1;
    #1;
  endtask

  // One commit for one cycle, then idle the commit port.
  task automatic commit(input word_t pc, input logic tk, input word_t dest);
    applyStimulus(1'b1, pc, tk, dest);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
  endtask

  // Compare {hit, taken, destpc} on one port with the expected triple.
  task automatic checkOutput(input string tag, input int port, input logic eh, input logic et, input word_t ed);
    logic [33:0] obs;
    logic [33:0] exp;
    obs = {hitPredict[port], destpcPredict[port].taken, destpcPredict[port].destpc};
    exp = {eh, et, ed};
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s port%0d: observed hit/taken/dest=%h expected %h", tag, port, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    lookup(32'hbfc00000, 32'hbfc00000);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state: everything misses with zero outputs.
    checkOutput("resetP0", 0, 1'b0, 1'b0, 32'h0);
    checkOutput("resetP1", 1, 1'b0, 1'b0, 32'h0);

    // Allocation; the same-cycle lookup still sees the empty entry.
    lookup(32'h80000010, 32'h80000010);
    applyStimulus(1'b1, 32'h80000010, 1'b1, 32'h80000100);
    #1;
    checkOutput("sameCycleOld", 0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checkOutput("allocWnt", 0, 1'b1, 1'b0, 32'h80000100);

    // Training: WNT -> ST -> WT -> SNT; not-taken never rewrites destpc.
    commit(32'h80000010, 1'b1, 32'h80000100);
    checkOutput("trainSt", 0, 1'b1, 1'b1, 32'h80000100);
    commit(32'h80000010, 1'b0, 32'h0);
    checkOutput("trainWt", 0, 1'b1, 1'b1, 32'h80000100);
    commit(32'h80000010, 1'b0, 32'h0);
    checkOutput("trainSnt", 1, 1'b1, 1'b0, 32'h80000100);

    // Not-taken miss does not allocate; stalled taken commit is dropped.
    lookup(32'h80000030, 32'h80000010);
    commit(32'h80000030, 1'b0, 32'h80000300);
    checkOutput("ntMiss", 0, 1'b0, 1'b0, 32'h0);
    stall = 1'b1;
    commit(32'h80000030, 1'b1, 32'h80000300);
    checkOutput("stallNoAlloc", 0, 1'b0, 1'b0, 32'h0);
    checkOutput("stallLookup", 1, 1'b1, 1'b0, 32'h80000100);
    stall = 1'b0;

    // Conflict in set 4: start from a clean table.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lookup(32'h80000010, 32'h80000410);
    checkOutput("resetAgain", 0, 1'b0, 1'b0, 32'h0);
    commit(32'h80000010, 1'b1, 32'h80001000);
    commit(32'h80000410, 1'b1, 32'h80002000);
    commit(32'h80000810, 1'b1, 32'h80003000);
    checkOutput("evictWay0", 0, 1'b0, 1'b0, 32'h0);
    checkOutput("keepWay1", 1, 1'b1, 1'b0, 32'h80002000);
    lookup(32'h80000810, 32'h80000410);
    checkOutput("newInWay0", 0, 1'b1, 1'b0, 32'h80003000);
    // Victim pointer now 1: the next conflict evicts way 1.
    commit(32'h80000c10, 1'b1, 32'h80004000);
    checkOutput("evictWay1", 1, 1'b0, 1'b0, 32'h0);
    checkOutput("survivorWay0", 0, 1'b1, 1'b0, 32'h80003000);
    lookup(32'h80000c10, 32'h80000810);
    checkOutput("newInWay1", 0, 1'b1, 1'b0, 32'h80004000);

    // Destination refresh on a taken hit; both ports agree.
    lookup(32'h80000020, 32'h80000020);
    commit(32'h80000020, 1'b1, 32'h80000100);
    checkOutput("refreshAlloc", 0, 1'b1, 1'b0, 32'h80000100);
    commit(32'h80000020, 1'b1, 32'h80000200);
    checkOutput("refreshP0", 0, 1'b1, 1'b1, 32'h80000200);
    checkOutput("refreshP1", 1, 1'b1, 1'b1, 32'h80000200);
    commit(32'h80000020, 1'b0, 32'hdeadbeec);
    checkOutput("ntKeepsDest", 0, 1'b1, 1'b1, 32'h80000200);

    // Flush with a simultaneous commit: everything invalid, nothing allocated.
    flush = 1'b1;
    commit(32'h80000040, 1'b1, 32'h80000400);
    flush = 1'b0;
    checkOutput("flushOld", 0, 1'b0, 1'b0, 32'h0);
    lookup(32'h80000040, 32'h80000810);
    checkOutput("flushDropWen", 0, 1'b0, 1'b0, 32'h0);
    checkOutput("flushSet4", 1, 1'b0, 1'b0, 32'h0);

    // After flush the set refills from way 0 (victim pointer cleared).
    lookup(32'h80000810, 32'h80000c10);
    commit(32'h80000810, 1'b1, 32'h80005000);
    commit(32'h80000c10, 1'b1, 32'h80006000);
    commit(32'h80000010, 1'b1, 32'h80007000);
    checkOutput("postFlushVictim", 0, 1'b0, 1'b0, 32'h0);
    checkOutput("postFlushKeep", 1, 1'b1, 1'b0, 32'h80006000);

    // Flush takes effect even while stalled.
    stall = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    #1;
    checkOutput("flushUnderStall", 1, 1'b0, 1'b0, 32'h0);

    // Reset over an update edge: the update is lost.
    lookup(32'h80000050, 32'h80000050);
    applyStimulus(1'b1, 32'h80000050, 1'b1, 32'h80000500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checkOutput("resetDropsWen", 0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
